prefetch_buffer: RTL and testbench

Parametrised instruction prefetch queue between instruction memory and decode, replacing the single-cycle combinational fetch path. It issues in-order fetch requests one outstanding at a time and buffers up to DEPTH instructions with their PCs. It presents them to decode through a valid/ready handshake. It also handles branch redirects, which flush the queue and squash any in-flight response, and it detects the halt opcode.

---
 rtl/prefetch_buffer_if.sv | 37 +++
 rtl/prefetch_buffer.sv | 127 ++++++++++++
 tb/tb_prefetch_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_buffer_if                                                   |
// | Fetch-side memory bus plus decode-side handshake for prefetch_buffer.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface prefetch_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] pc_out;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CW-1:0]     count;
    logic              hlt;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, pc_out, count, hlt,
        input  imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, pc_out, count, hlt,
        output imem_rvalid, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/prefetch_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prefetch_buffer                                                      |
// | In-order instruction prefetch queue with redirect flush/squash and   |
// | halt detection. Optional same-cycle bypass: PREFETCH_BYPASS_EN.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module prefetch_buffer #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_INC   = 2,
    parameter logic [3:0]        HALT_OP  = 4'hF
) (
    input logic               clk,
    input logic               rst,
    prefetch_buffer_if.master bus
);
    localparam int                PW       = $clog2(DEPTH);
    localparam int                CW       = $clog2(DEPTH + 1);
    localparam int                CW1      = CW + 1;
    localparam logic [CW:0]       c_DEPTH  = CW1'(DEPTH);
    localparam logic [ADDR_W-1:0] c_INC    = ADDR_W'(PC_INC);
    localparam logic [PW-1:0]     c_PTR1   = PW'(1);

    logic [DATA_W-1:0] r_instr [DEPTH];
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [CW-1:0]     r_count;
    logic [ADDR_W-1:0] r_fetch_pc, r_req_addr;
    logic              r_out, r_squash, r_stop, r_halted;

    logic              w_redir, w_resp, w_accept, w_rd_halt, w_unres, w_space;
    logic              w_issue, w_empty, w_byp, w_valid, w_xfer, w_deq, w_enq;
    logic              w_xfer_halt;
    logic [CW:0]       w_occ;
    logic [ADDR_W-1:0] w_issue_pc, w_out_pc;
    logic [DATA_W-1:0] w_out_instr;

    assign w_redir    = bus.redirect & ~r_halted;
    assign w_resp     = r_out & bus.imem_rvalid;
    assign w_accept   = w_resp & ~r_squash & ~w_redir;
    assign w_rd_halt  = (bus.imem_rdata[DATA_W-1 -: 4] == HALT_OP);
    // A live outstanding request already owns a queue slot.
    assign w_unres    = r_out & ~r_squash;
    assign w_occ      = {1'b0, r_count} + {{CW{1'b0}}, w_unres};
    assign w_space    = (w_occ < c_DEPTH);
    assign w_issue    = ~rst & ~r_halted & ~r_stop & ~bus.redirect
                      & (~r_out | bus.imem_rvalid) & w_space
                      & ~(w_accept & w_rd_halt);
    assign w_issue_pc = w_accept ? (r_fetch_pc + c_INC) : r_fetch_pc;
    assign w_empty    = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
    assign w_byp = w_empty & w_accept;
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid     = ~rst & ~r_halted & (~w_empty | w_byp);
    assign w_out_instr = w_empty ? bus.imem_rdata : r_instr[r_rd];
    assign w_out_pc    = w_empty ? r_req_addr     : r_pc[r_rd];
    assign w_xfer      = w_valid & bus.instr_ready;
    assign w_deq       = w_xfer & ~w_empty;
    assign w_enq       = w_accept & ~(w_byp & bus.instr_ready);
    assign w_xfer_halt = w_xfer & (w_out_instr[DATA_W-1 -: 4] == HALT_OP);

    assign bus.imem_req    = w_issue;
    assign bus.imem_addr   = rst ? '0 : (w_issue ? w_issue_pc : r_req_addr);
    assign bus.instr_valid = w_valid;
    assign bus.instr_out   = w_valid ? w_out_instr : '0;
    assign bus.pc_out      = w_valid ? w_out_pc : '0;
    assign bus.count       = rst ? '0 : r_count;
    assign bus.hlt         = ~rst & r_halted;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr[r_wr] <= bus.imem_rdata;
            r_pc[r_wr]    <= r_req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_out      <= 1'b0;
            r_squash   <= 1'b0;
            r_stop     <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_out      <= 1'b1;
                r_req_addr <= w_issue_pc;
            end else if (w_resp) begin
                r_out <= 1'b0;
            end
            if (w_resp & r_squash) r_squash <= 1'b0;
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + c_INC;
                if (w_rd_halt) r_stop <= 1'b1;
            end
            if (w_enq) r_wr <= r_wr + c_PTR1;
            if (w_deq) r_rd <= r_rd + c_PTR1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_xfer_halt & ~bus.redirect) r_halted <= 1'b1;
            // Redirect overrides every queue/fetch update above.
            if (w_redir) begin
                r_count    <= '0;
                r_wr       <= '0;
                r_rd       <= '0;
                r_fetch_pc <= bus.redirect_pc;
                r_stop     <= 1'b0;
                r_squash   <= r_out & ~bus.imem_rvalid;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// Self-checking bench for prefetch_buffer: memory responder with variable
// latency plus a queue-based reference model of the fetch/decode rules.
module tb_prefetch_buffer;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int VW    = 1 + AW + 1 + DW + AW + CW + 1;
    typedef logic [VW-1:0] vec_t;
    typedef struct packed { logic [DW-1:0] instr; logic [AW-1:0] pc; } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prefetch_buffer_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

    prefetch_buffer #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC(16'h0000),
        .PC_INC(2), .HALT_OP(4'hF)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          lat_min = 1, lat_max = 1;
    logic        halt_en = 1'b0;
    logic [AW-1:0] halt_addr = '0;
    logic        pend = 1'b0;
    int          mwait = 0;
    logic [AW-1:0] paddr = '0;

    ent_t          m_q[$];
    logic [AW-1:0] m_fpc, m_reqaddr;
    logic          m_out, m_squash, m_stop, m_halt;

    logic          o_req, o_valid, o_hlt, o_rv, s_rst;
    logic [AW-1:0] o_addr, o_pc;
    logic [DW-1:0] o_instr;
    logic [CW-1:0] o_count;
    vec_t          obs_v, exp_v;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        if (halt_en && a == halt_addr) return 16'hF000;
        w = (a * 16'h9E37) ^ 16'h3C5A;
        if (w[DW-1 -: 4] == 4'hF) w[DW-1 -: 4] = 4'h7;
        return w;
    endfunction

    // Sample outputs, predict them from the model, then advance one clock.
    task automatic tick();
        int            sz;
        logic          redir, resp, accept, rdh, byp, valid, req, xfer, old_out;
        logic [AW-1:0] addr;
        ent_t          head, e;
        #2;
        o_req = bus.imem_req;     o_addr  = bus.imem_addr;
        o_valid = bus.instr_valid; o_instr = bus.instr_out;
        o_pc = bus.pc_out;        o_count = bus.count;
        o_hlt = bus.hlt;          o_rv    = bus.imem_rvalid;
        s_rst = rst;
        obs_v = {o_req, (o_req ? o_addr : 16'h0), o_valid, o_instr, o_pc, o_count, o_hlt};
        if (rst) begin
            exp_v = '0;
            m_q.delete();
            m_fpc = 16'h0000; m_reqaddr = '0;
            m_out = 1'b0; m_squash = 1'b0; m_stop = 1'b0; m_halt = 1'b0;
        end else begin
            sz     = m_q.size();
            redir  = bus.redirect && !m_halt;
            resp   = m_out && bus.imem_rvalid;
            accept = resp && !m_squash && !redir;
            rdh    = (bus.imem_rdata[DW-1 -: 4] == 4'hF);
            byp    = 1'b0;
`ifdef PREFETCH_BYPASS_EN
            byp    = (sz == 0) && accept;
`endif
            valid  = !m_halt && (sz > 0 || byp);
            head   = '0;
            if (valid) begin
                if (sz > 0) head = m_q[0];
                else begin head.instr = bus.imem_rdata; head.pc = m_reqaddr; end
            end
            req  = !m_halt && !m_stop && !bus.redirect && (!m_out || bus.imem_rvalid)
                && (sz + int'(m_out && !m_squash) < DEPTH) && !(accept && rdh);
            addr = accept ? m_fpc + 16'd2 : m_fpc;
            exp_v = {req, (req ? addr : 16'h0), valid, head.instr, head.pc, CW'(sz), m_halt};
            xfer = valid && bus.instr_ready;
            if (xfer && sz > 0) void'(m_q.pop_front());
            if (accept && !(byp && bus.instr_ready)) begin
                e.instr = bus.imem_rdata; e.pc = m_reqaddr;
                m_q.push_back(e);
            end
            if (accept) begin
                m_fpc = m_fpc + 16'd2;
                if (rdh) m_stop = 1'b1;
            end
            if (resp && m_squash) m_squash = 1'b0;
            old_out = m_out;
            if (req) begin m_out = 1'b1; m_reqaddr = addr; end
            else if (resp) m_out = 1'b0;
            if (xfer && head.instr[DW-1 -: 4] == 4'hF && !bus.redirect) m_halt = 1'b1;
            if (redir) begin
                m_q.delete();
                m_fpc    = bus.redirect_pc;
                m_stop   = 1'b0;
                m_squash = old_out && !bus.imem_rvalid;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) pend = 1'b0;
        else begin
            if (o_rv) pend = 1'b0;
            if (o_req) begin
                pend = 1'b1; paddr = o_addr;
                mwait = int'($urandom_range(lat_max, lat_min));
            end
        end
        if (pend) begin mwait--; bus.imem_rvalid = (mwait == 0); end
        else bus.imem_rvalid = 1'b0;
        bus.imem_rdata = bus.imem_rvalid ? mem_word(paddr) : 16'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.redirect = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.redirect = 1'b0; bus.instr_ready = 1'b1;
        lat_min = 1; lat_max = 1; halt_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs_v !== '0) begin
                errors++; $display("FAIL reset_outputs got=%h exp=0", obs_v);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (!(o_req === 1'b1 && o_addr === 16'h0000)) begin
            errors++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0000", o_req, o_addr);
        end
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset_model got=%h exp=%h", obs_v, exp_v);
        end
    endtask

    task automatic test_stream();
        int first_rv = -1, first_v = -1, exp_lat;
        logic [AW-1:0] pcs[$];
        int            vc[$];
        lat_min = 1; lat_max = 1; bus.instr_ready = 1'b1;
        do_reset();
        repeat (12) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (o_rv && first_rv < 0) first_rv = cyc;
            if (o_valid) begin
                if (first_v < 0) first_v = cyc;
                pcs.push_back(o_pc); vc.push_back(cyc);
            end
        end
`ifdef PREFETCH_BYPASS_EN
        exp_lat = 0;
`else
        exp_lat = 1;
`endif
        checks++;
        if (first_rv < 0 || first_v - first_rv != exp_lat) begin
            errors++; $display("FAIL stream_latency got=%0d exp=%0d", first_v - first_rv, exp_lat);
        end
        checks++;
        if (pcs.size() < 3 || pcs[0] !== 16'h0000 || pcs[1] !== 16'h0002 || pcs[2] !== 16'h0004
            || vc[1] != vc[0] + 1 || vc[2] != vc[0] + 2) begin
            errors++; $display("FAIL stream_pcs got_n=%0d exp pcs 0000,0002,0004 consecutive", pcs.size());
        end
    endtask

    task automatic test_backpressure();
        int nresp = 0, nreq = 0;
        lat_min = 1; lat_max = 1; bus.instr_ready = 1'b0;
        do_reset();
        repeat (10) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL bp_fill cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (o_rv) nresp++;
        end
        checks++;
        if (nresp != 4 || o_count !== 3'd4 || o_req !== 1'b0) begin
            errors++; $display("FAIL bp_full got resp=%0d count=%0d req=%b exp 4,4,0", nresp, o_count, o_req);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick();
        checks++;
        if (o_count !== 3'd3 || o_req !== 1'b1 || o_addr !== 16'h0008) begin
            errors++; $display("FAIL bp_drain got count=%0d req=%b addr=%h exp 3,1,0008", o_count, o_req, o_addr);
        end
        repeat (4) begin
            tick();
            if (o_req) nreq++;
        end
        checks++;
        if (nreq != 0 || o_count !== 3'd4) begin
            errors++; $display("FAIL bp_refill got reqs=%0d count=%0d exp 0,4", nreq, o_count);
        end
    endtask

    task automatic test_redirect();
        int   n = 0;
        logic found = 1'b0, seen_v = 1'b0, seen_req = 1'b0, bad = 1'b0;
        logic [AW-1:0] req_a = '0, v_pc = '0;
        lat_min = 3; lat_max = 3; bus.instr_ready = 1'b1;
        do_reset();
        while (!found && n < 60) begin
            tick(); n++;
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL redir_pre cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (o_req && o_addr == 16'h0006) found = 1'b1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL redir_find got=none exp=req 0006"); end
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
        tick();
        bus.redirect = 1'b0;
        for (int i = 0; i < 40 && !seen_v; i++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL redir_post cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (o_req && !seen_req) begin seen_req = 1'b1; req_a = o_addr; end
            if (o_valid) begin seen_v = 1'b1; v_pc = o_pc; end
            else if (o_count !== '0) bad = 1'b1;
        end
        checks++;
        if (!seen_req || req_a !== 16'h0040) begin
            errors++; $display("FAIL redir_req got=%h exp=0040", req_a);
        end
        checks++;
        if (!seen_v || v_pc !== 16'h0040 || bad) begin
            errors++; $display("FAIL redir_pc got=%h nonzero_count=%b exp=0040,0", v_pc, bad);
        end
    endtask

    task automatic test_halt();
        int   hx = -1, hr = -1;
        logic saw8 = 1'b0, dropped = 1'b0, late_req = 1'b0;
        lat_min = 1; lat_max = 1; bus.instr_ready = 1'b1;
        halt_en = 1'b1; halt_addr = 16'h0006;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL halt_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
            if (o_req && o_addr == 16'h0008) saw8 = 1'b1;
            if (o_valid && o_pc == 16'h0006 && hx < 0) hx = n;
            if (o_hlt && hr < 0) hr = n;
            if (hr >= 0 && !o_hlt) dropped = 1'b1;
        end
        checks++;
        if (saw8 || hx < 0 || hr != hx + 1 || dropped) begin
            errors++; $display("FAIL halt_rise got xfer=%0d hlt=%0d req8=%b drop=%b exp hlt=xfer+1", hx, hr, saw8, dropped);
        end
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0080;
        tick();
        bus.redirect = 1'b0;
        repeat (5) begin
            tick();
            if (o_req || !o_hlt) late_req = 1'b1;
        end
        checks++;
        if (late_req) begin errors++; $display("FAIL halt_redirect got req_or_hlt_drop=1 exp=0"); end
        halt_en = 1'b0;
    endtask

    task automatic test_redirect_on_halt();
        logic hit = 1'b0, hl = 1'b0, seen_req = 1'b0;
        logic [AW-1:0] req_a = '0;
        lat_min = 1; lat_max = 1; bus.instr_ready = 1'b1;
        halt_en = 1'b1; halt_addr = 16'h0006;
        do_reset();
        for (int n = 0; n < 30 && !hit; n++) begin
            #1;
            if (bus.instr_valid && bus.pc_out == 16'h0006) begin
                bus.redirect = 1'b1; bus.redirect_pc = 16'h0100; hit = 1'b1;
            end
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL rh_run cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
        bus.redirect = 1'b0;
        checks++;
        if (!hit) begin errors++; $display("FAIL rh_find got=none exp=halt at 0006"); end
        repeat (10) begin
            tick();
            if (o_hlt) hl = 1'b1;
            if (o_req && !seen_req) begin seen_req = 1'b1; req_a = o_addr; end
        end
        checks++;
        if (hl || !seen_req || req_a !== 16'h0100) begin
            errors++; $display("FAIL rh_resume got hlt=%b req=%h exp hlt=0 req=0100", hl, req_a);
        end
        halt_en = 1'b0;
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4; halt_en = 1'b0;
        bus.instr_ready = 1'b1;
        do_reset();
        repeat (400) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                bus.redirect = 1'b1;
                bus.redirect_pc = 16'($urandom_range(0, 255) * 2);
            end else bus.redirect = 1'b0;
            tick();
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
            end
        end
        bus.redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_redirect_on_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
